// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
//   stage_state_e  : occupancy state of one elastic stage (empty / one entry / two entries)
//   ID_EX_W        : packed payload width of the ID/EX boundary bundle
//   EX_MEM_W       : packed payload width of the EX/MEM boundary bundle
//   stage_has_data : true when a stage presents a payload downstream
package pipe_pkg;

  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,  // main and skid entries both invalid
    STAGE_FULL  = 2'd1,  // main entry valid, skid entry invalid
    STAGE_SKID  = 2'd2   // main and skid entries both valid
  } stage_state_e;

  localparam int ID_EX_W  = 64;
  localparam int EX_MEM_W = 72;

  function automatic logic stage_has_data(input stage_state_e s);
    return (s != STAGE_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used to count stall cycles at a stage boundary.
// Ports:
//   clk   in         clock
//   rst_n in         synchronous active-low reset, clears the count
//   inc   in         add one this cycle (ignored once saturated)
//   cnt   out CNT_W  current count
//   sat   out        count is at its maximum value 2^CNT_W-1
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !sat) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register carrying one packed control+data bundle
// between MIPS pipeline stages with a valid/ready handshake, flush and stall.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. A producer holding valid may not withdraw it or change the
// payload until the transfer; ready may change freely. out_data/out_valid stay
// stable while out_valid & !out_ready.
//
// Ports:
//   clk        in          clock, all state updates on rising edge
//   rst_n      in          synchronous active-low reset
//   flush      in          discard all held entries (input accepted this cycle is dropped)
//   in_valid   in          upstream payload valid
//   in_ready   out         stage can accept
//   in_data    in  DATA_W  upstream payload
//   out_valid  out         payload presented downstream
//   out_ready  in          downstream accepts
//   out_data   out DATA_W  downstream payload
//   stall_cnt  out CNT_W   saturating stall-cycle count (only with PIPE_STAGE_STALL_CNT_EN)
//
// Parameters: DATA_W payload width; SKID=1 two-entry skid buffer with a
// registered in_ready, SKID=0 single register with combinational in_ready;
// CNT_W stall counter width (only with PIPE_STAGE_STALL_CNT_EN).
//
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds the stall_cnt port and
// its counter. The occupancy state is held in state_q (stage_state_e).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_W,
  parameter int SKID   = 1
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;

  assign out_valid = stage_has_data(state_q);
  assign out_data  = main_q;

  // With the skid buffer, in_ready is a flop so the upstream ready path is
  // cut; the skid entry absorbs the one payload that arrives in the cycle
  // out_ready falls. Without it, in_ready looks straight through to out_ready.
  assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload registers keep their contents; out_valid=0 makes them don't-care.
      state_d = STAGE_EMPTY;
    end else begin
      unique case (state_q)
        STAGE_EMPTY: begin
          if (accept) begin
            state_d = STAGE_FULL;
            main_d  = in_data;
          end
        end
        STAGE_FULL: begin
          if (accept && out_ready) begin
            main_d = in_data;
          end else if (accept) begin
            // Only reachable with SKID=1; SKID=0 holds in_ready low here.
            state_d = STAGE_SKID;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = STAGE_EMPTY;
          end
        end
        STAGE_SKID: begin
          if (out_ready) begin
            state_d = STAGE_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = STAGE_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != STAGE_SKID);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= STAGE_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic stall_sat;
  logic stall_inc;

  // Counter sits outside the flush path: flush clears entries, not statistics.
  assign stall_inc = out_valid & ~out_ready & ~stall_sat;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .cnt  (stall_cnt),
    .sat  (stall_sat)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance driven through reset, streaming,
// backpressure, flush, reset-mid-stall and random traffic with a scoreboard
// queue, plus a SKID=0 instance for the combinational ready path. With
// PIPE_STAGE_STALL_CNT_EN defined, the stall counter (CNT_W=4) is also checked.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = ID_EX_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [W-1:0] s0_in_data, s0_out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0]   stall_cnt;
  logic [15:0]  s0_stall_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W(W),
    .SKID  (1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .CNT_W (4)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  pipe_stage_reg #(
    .DATA_W(W),
    .SKID  (0)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .CNT_W (16)
`endif
  ) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (s0_flush),
    .in_valid (s0_in_valid),
    .in_ready (s0_in_ready),
    .in_data  (s0_in_data),
    .out_valid(s0_out_valid),
    .out_ready(s0_out_ready),
    .out_data (s0_out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(s0_stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  logic         stalled_prev;
  logic [W-1:0] held_data;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the SKID=1 instance. Inputs are already driven; the
  // handshake is sampled on the falling edge, then the rising edge is taken.
  task automatic step();
    logic [W-1:0] exp;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        check("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=%h expected=no_output", out_data);
        end
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("sb_data", out_data, exp);
        end
      end
      stalled_prev = out_valid && !out_ready && !flush;
      held_data    = out_data;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    check("drain_empty", W'(exp_q.size()), '0);
    step();
    check("drain_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] seq;
    checks = 0;
    errors = 0;
    stalled_prev = 1'b0;
    held_data = '0;
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b1; in_data = W'(8'hAA); out_ready = 1'b0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0;

    // 1. reset held 3 cycles with input offered
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready_before_edge", {{(W-1){1'b0}}, in_ready}, '0);
    step();
    check("rel_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});

    // 2. streaming 1..8 with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      check("stream_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
      step();
      check("stream_latency", out_data, W'(i));
    end
    drain();

    // 3. backpressure
    in_valid = 1'b1; in_data = W'(8'h10); out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_data = W'(8'h11);
    step();
    in_data = W'(8'h12);
    check("bp_in_ready_low", {{(W-1){1'b0}}, in_ready}, '0);
    check("bp_out_data", out_data, W'(8'h10));
    step();
    step();
    check("bp_out_data_held", out_data, W'(8'h10));
    out_ready = 1'b1;
    step();
    check("bp_skid_to_main", out_data, W'(8'h11));
    step();
    check("bp_last", out_data, W'(8'h12));
    drain();

    // 4. flush while in SKID, 0x55 offered and dropped
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h20);
    step();
    in_data = W'(8'h21);
    step();
    check("fl_in_skid", {{(W-1){1'b0}}, in_ready}, '0);
    flush = 1'b1; in_data = W'(8'h55);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    check("fl_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    out_ready = 1'b1;
    repeat (3) step();
    check("fl_no_55", {{(W-1){1'b0}}, out_valid}, '0);

    // flush in FULL with a simultaneous accept: that input is discarded too
    in_valid = 1'b1; in_data = W'(8'h30); out_ready = 1'b0;
    step();
    flush = 1'b1; in_data = W'(8'h56);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_full_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    step();
    check("fl_full_no_56", {{(W-1){1'b0}}, out_valid}, '0);

    // reset mid-stall discards both entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h40);
    step();
    in_data = W'(8'h41);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_stall_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    check("rst_stall_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
    step();
    out_ready = 1'b1;
    step();
    check("rst_stall_empty", {{(W-1){1'b0}}, out_valid}, '0);

    // random traffic through the scoreboard
    seq = W'(32'h1000);
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = seq;
      out_ready = ($urandom_range(0, 3) != 0);
      seq       = seq + W'(1);
      step();
    end
    drain();

    // 5. SKID=0 instance: combinational in_ready
    s0_in_valid = 1'b1; s0_in_data = W'(8'h77); s0_out_ready = 1'b0;
    @(posedge clk); #1;
    check("s0_out_valid", {{(W-1){1'b0}}, s0_out_valid}, {{(W-1){1'b0}}, 1'b1});
    check("s0_in_ready_low", {{(W-1){1'b0}}, s0_in_ready}, '0);
    s0_in_data = W'(8'h78);
    @(posedge clk); #1;
    check("s0_hold", s0_out_data, W'(8'h77));
    s0_in_valid = 1'b0; s0_out_ready = 1'b1;
    #1;
    check("s0_in_ready_high", {{(W-1){1'b0}}, s0_in_ready}, {{(W-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    check("s0_drained", {{(W-1){1'b0}}, s0_out_valid}, '0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // 6. stall counter saturation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("cnt_reset", W'(stall_cnt), '0);
    in_valid = 1'b1; in_data = W'(8'h60); out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_five", W'(stall_cnt), W'(5));
    repeat (15) @(posedge clk);
    #1;
    check("cnt_sat", W'(stall_cnt), W'(15));
    stalled_prev = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt_after_flush", W'(stall_cnt), W'(15));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("cnt_after_reset", W'(stall_cnt), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
